// File: rtl/wl_pkg.sv
// rtl/wl_pkg.sv - Wakelet shared types, AXI-Lite structs and CSR window constants
package wl_pkg;

  localparam int unsigned AxiAddrW = 32;
  localparam int unsigned AxiDataW = 32;
  localparam int unsigned AxiStrbW = AxiDataW / 8;

  localparam logic [AxiAddrW-1:0] CsrBaseAddr = 32'h1A10_4000;

  localparam int unsigned CsrNumRegs    = 4;
  localparam int unsigned CsrIdxCtrl    = 0;
  localparam int unsigned CsrIdxStatus  = 1;
  localparam int unsigned CsrIdxScratch = 2;
  localparam int unsigned CsrIdxCycles  = 3;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef struct packed {
    logic [AxiAddrW-1:0] aw_addr;
    logic                aw_valid;
    logic [AxiDataW-1:0] w_data;
    logic [AxiStrbW-1:0] w_strb;
    logic                w_valid;
    logic                b_ready;
    logic [AxiAddrW-1:0] ar_addr;
    logic                ar_valid;
    logic                r_ready;
  } axi_lite_req_t;

  typedef struct packed {
    logic                aw_ready;
    logic                w_ready;
    logic                b_valid;
    logic [1:0]          b_resp;
    logic                ar_ready;
    logic                r_valid;
    logic [AxiDataW-1:0] r_data;
    logic [1:0]          r_resp;
  } axi_lite_resp_t;

  typedef enum logic [1:0] {
    WrIdle = 2'd0,
    WrHold = 2'd1,
    WrResp = 2'd2
  } wr_state_e;

  typedef enum logic {
    RdIdle = 1'b0,
    RdResp = 1'b1
  } rd_state_e;

  // Replace only the bytes whose strobe is set.
  function automatic logic [AxiDataW-1:0] strb_merge(
    input logic [AxiDataW-1:0] old_w,
    input logic [AxiDataW-1:0] new_w,
    input logic [AxiStrbW-1:0] strb
  );
    logic [AxiDataW-1:0] res;
    res = old_w;
    for (int b = 0; b < int'(AxiStrbW); b++) begin
      if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/wl_csr_regfile.sv
// rtl/wl_csr_regfile.sv - CSR storage: control, eoc sticky, scratch words, cycle counter
module wl_csr_regfile
  import wl_pkg::*;
#(
  parameter int unsigned NumRegs = CsrNumRegs
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       wr_en_i,
  input  logic [$clog2(NumRegs)-1:0] wr_idx_i,
  input  logic [AxiDataW-1:0]        wr_data_i,
  input  logic [AxiStrbW-1:0]        wr_strb_i,
  input  logic [$clog2(NumRegs)-1:0] rd_idx_i,
  output logic [AxiDataW-1:0]        rd_data_o,
  input  logic                       hwpe_busy_i,
  input  logic                       hwpe_eoc_i,
  output logic                       fetch_en_o,
  output logic                       hwpe_clear_o
);

  localparam int unsigned IdxW = $clog2(NumRegs);

  logic                              fetch_en_q, fetch_en_d;
  logic                              clear_q, clear_d;
  logic                              eoc_sticky_q, eoc_sticky_d;
  logic [AxiDataW-1:0]               cycles_q, cycles_d;
  logic [NumRegs-1:0][AxiDataW-1:0]  scratch_q, scratch_d;

  logic wr_ctrl, wr_status, wr_cycles;

  assign wr_ctrl   = wr_en_i && (wr_idx_i == IdxW'(CsrIdxCtrl));
  assign wr_status = wr_en_i && (wr_idx_i == IdxW'(CsrIdxStatus));
  assign wr_cycles = wr_en_i && (wr_idx_i == IdxW'(CsrIdxCycles));

  // Next-state for every register; eoc set beats clear, counter write beats increment.
  always_comb begin
    fetch_en_d   = fetch_en_q;
    clear_d      = 1'b0;
    eoc_sticky_d = eoc_sticky_q;
    scratch_d    = scratch_q;
    if (wr_ctrl && wr_strb_i[0]) begin
      fetch_en_d = wr_data_i[0];
      clear_d    = wr_data_i[1];
    end
    if (wr_status && wr_strb_i[0] && wr_data_i[1]) eoc_sticky_d = 1'b0;
    if (hwpe_eoc_i) eoc_sticky_d = 1'b1;
    cycles_d = wr_cycles ? '0 : cycles_q + 32'd1;
    for (int unsigned i = 0; i < NumRegs; i++) begin
      if ((i == CsrIdxScratch || i > CsrIdxCycles) && wr_en_i && (wr_idx_i == IdxW'(i))) begin
        scratch_d[i] = strb_merge(scratch_q[i], wr_data_i, wr_strb_i);
      end
    end
  end

  // Register state; entries of scratch_q at fixed-function indices stay at zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_en_q   <= 1'b0;
      clear_q      <= 1'b0;
      eoc_sticky_q <= 1'b0;
      cycles_q     <= '0;
      scratch_q    <= '0;
    end else begin
      fetch_en_q   <= fetch_en_d;
      clear_q      <= clear_d;
      eoc_sticky_q <= eoc_sticky_d;
      cycles_q     <= cycles_d;
      scratch_q    <= scratch_d;
    end
  end

  // Read mux; CTRL bit1 is a pulse and always reads back as zero.
  always_comb begin
    rd_data_o = '0;
    if (rd_idx_i == IdxW'(CsrIdxCtrl)) begin
      rd_data_o = {31'b0, fetch_en_q};
    end else if (rd_idx_i == IdxW'(CsrIdxStatus)) begin
      rd_data_o = {30'b0, eoc_sticky_q, hwpe_busy_i};
    end else if (rd_idx_i == IdxW'(CsrIdxCycles)) begin
      rd_data_o = cycles_q;
    end else begin
      rd_data_o = scratch_q[rd_idx_i];
    end
  end

  assign fetch_en_o   = fetch_en_q;
  assign hwpe_clear_o = clear_q;

endmodule

// File: rtl/wl_csr_axi_lite_slv.sv
// rtl/wl_csr_axi_lite_slv.sv - AXI-Lite CSR responder; WL_CSR_ERR_RESP_EN selects SLVERR for out-of-range
module wl_csr_axi_lite_slv
  import wl_pkg::*;
#(
  parameter int unsigned         NumRegs  = CsrNumRegs,
  parameter logic [AxiAddrW-1:0] BaseAddr = CsrBaseAddr
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  axi_lite_req_t  axi_lite_req_i,
  output axi_lite_resp_t axi_lite_rsp_o,
  input  logic           hwpe_busy_i,
  input  logic           hwpe_eoc_i,
  output logic           fetch_en_o,
  output logic           hwpe_clear_o
);

  localparam int unsigned IdxW = $clog2(NumRegs);

`ifdef WL_CSR_ERR_RESP_EN
  localparam logic [1:0] OorResp = RespSlvErr;
`else
  localparam logic [1:0] OorResp = RespOkay;
`endif

  // Returns {hit, word index}; hit is false below the base or past the last word.
  function automatic logic [IdxW:0] decode(input logic [AxiAddrW-1:0] addr);
    logic [AxiAddrW-1:0] off;
    logic                hit;
    off = addr - BaseAddr;
    hit = (addr >= BaseAddr) && (off < AxiAddrW'(NumRegs * 4));
    return {hit, off[IdxW+1:2]};
  endfunction

  logic                en_q;
  wr_state_e           wr_state_q, wr_state_d;
  logic                aw_full_q, aw_full_d;
  logic [AxiAddrW-1:0] aw_addr_q, aw_addr_d;
  logic                w_full_q, w_full_d;
  logic [AxiDataW-1:0] w_data_q, w_data_d;
  logic [AxiStrbW-1:0] w_strb_q, w_strb_d;
  logic [1:0]          b_resp_q, b_resp_d;
  rd_state_e           rd_state_q, rd_state_d;
  logic [AxiDataW-1:0] r_data_q, r_data_d;
  logic [1:0]          r_resp_q, r_resp_d;

  logic aw_ready, w_ready, ar_ready;
  logic aw_hs, w_hs, ar_hs;
  logic have_aw, have_w, commit;

  logic [AxiAddrW-1:0] wr_addr;
  logic [AxiDataW-1:0] wr_data;
  logic [AxiStrbW-1:0] wr_strb;
  logic [IdxW:0]       wr_dec, rd_dec;
  logic [AxiDataW-1:0] rf_rd_data;

  assign aw_ready = en_q && !aw_full_q && (wr_state_q != WrResp);
  assign w_ready  = en_q && !w_full_q && (wr_state_q != WrResp);
  assign ar_ready = en_q && (rd_state_q == RdIdle);

  assign aw_hs = axi_lite_req_i.aw_valid && aw_ready;
  assign w_hs  = axi_lite_req_i.w_valid && w_ready;
  assign ar_hs = axi_lite_req_i.ar_valid && ar_ready;

  // A write commits on the edge where both halves are available, held or arriving.
  assign have_aw = aw_full_q || aw_hs;
  assign have_w  = w_full_q || w_hs;
  assign commit  = (wr_state_q != WrResp) && have_aw && have_w;

  assign wr_addr = aw_full_q ? aw_addr_q : axi_lite_req_i.aw_addr;
  assign wr_data = w_full_q ? w_data_q : axi_lite_req_i.w_data;
  assign wr_strb = w_full_q ? w_strb_q : axi_lite_req_i.w_strb;
  assign wr_dec  = decode(wr_addr);
  assign rd_dec  = decode(axi_lite_req_i.ar_addr);

  wl_csr_regfile #(
    .NumRegs (NumRegs)
  ) u_regfile (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .wr_en_i      (commit && wr_dec[IdxW]),
    .wr_idx_i     (wr_dec[IdxW-1:0]),
    .wr_data_i    (wr_data),
    .wr_strb_i    (wr_strb),
    .rd_idx_i     (rd_dec[IdxW-1:0]),
    .rd_data_o    (rf_rd_data),
    .hwpe_busy_i  (hwpe_busy_i),
    .hwpe_eoc_i   (hwpe_eoc_i),
    .fetch_en_o   (fetch_en_o),
    .hwpe_clear_o (hwpe_clear_o)
  );

  // Write channel: capture AW/W independently, commit, then hold B until accepted.
  always_comb begin
    wr_state_d = wr_state_q;
    aw_full_d  = aw_full_q;
    aw_addr_d  = aw_addr_q;
    w_full_d   = w_full_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    b_resp_d   = b_resp_q;
    case (wr_state_q)
      WrIdle, WrHold: begin
        if (commit) begin
          aw_full_d  = 1'b0;
          w_full_d   = 1'b0;
          b_resp_d   = wr_dec[IdxW] ? RespOkay : OorResp;
          wr_state_d = WrResp;
        end else begin
          if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_addr_d = axi_lite_req_i.aw_addr;
          end
          if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = axi_lite_req_i.w_data;
            w_strb_d = axi_lite_req_i.w_strb;
          end
          wr_state_d = (aw_full_d || w_full_d) ? WrHold : WrIdle;
        end
      end
      WrResp: begin
        if (axi_lite_req_i.b_ready) begin
          wr_state_d = WrIdle;
          b_resp_d   = RespOkay;
        end
      end
      default: wr_state_d = WrIdle;
    endcase
  end

  // Read channel: data is sampled at AR accept so a same-edge write is not visible.
  always_comb begin
    rd_state_d = rd_state_q;
    r_data_d   = r_data_q;
    r_resp_d   = r_resp_q;
    case (rd_state_q)
      RdIdle: begin
        if (ar_hs) begin
          r_data_d   = rd_dec[IdxW] ? rf_rd_data : '0;
          r_resp_d   = rd_dec[IdxW] ? RespOkay : OorResp;
          rd_state_d = RdResp;
        end
      end
      RdResp: begin
        if (axi_lite_req_i.r_ready) rd_state_d = RdIdle;
      end
      default: rd_state_d = RdIdle;
    endcase
  end

  // Channel state; en_q keeps every ready low until the first edge after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q       <= 1'b0;
      wr_state_q <= WrIdle;
      aw_full_q  <= 1'b0;
      aw_addr_q  <= '0;
      w_full_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      b_resp_q   <= RespOkay;
      rd_state_q <= RdIdle;
      r_data_q   <= '0;
      r_resp_q   <= RespOkay;
    end else begin
      en_q       <= 1'b1;
      wr_state_q <= wr_state_d;
      aw_full_q  <= aw_full_d;
      aw_addr_q  <= aw_addr_d;
      w_full_q   <= w_full_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      b_resp_q   <= b_resp_d;
      rd_state_q <= rd_state_d;
      r_data_q   <= r_data_d;
      r_resp_q   <= r_resp_d;
    end
  end

  // Pack the response struct.
  always_comb begin
    axi_lite_rsp_o          = '0;
    axi_lite_rsp_o.aw_ready = aw_ready;
    axi_lite_rsp_o.w_ready  = w_ready;
    axi_lite_rsp_o.b_valid  = (wr_state_q == WrResp);
    axi_lite_rsp_o.b_resp   = b_resp_q;
    axi_lite_rsp_o.ar_ready = ar_ready;
    axi_lite_rsp_o.r_valid  = (rd_state_q == RdResp);
    axi_lite_rsp_o.r_data   = r_data_q;
    axi_lite_rsp_o.r_resp   = r_resp_q;
  end

endmodule

// File: tb/tb_wl_csr_axi_lite_slv.sv
// tb/tb_wl_csr_axi_lite_slv.sv - directed self-checking bench for wl_csr_axi_lite_slv
module tb_wl_csr_axi_lite_slv;
  import wl_pkg::*;

  localparam logic [31:0] ACtrl   = CsrBaseAddr;
  localparam logic [31:0] AStatus = CsrBaseAddr + 32'h4;
  localparam logic [31:0] AScr    = CsrBaseAddr + 32'h8;
  localparam logic [31:0] ACyc    = CsrBaseAddr + 32'hC;

`ifdef WL_CSR_ERR_RESP_EN
  localparam logic [1:0] ExpOor = 2'b10;
`else
  localparam logic [1:0] ExpOor = 2'b00;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  axi_lite_req_t  req;
  axi_lite_resp_t rsp;
  logic           busy, eoc, fetch_en, clr;
  logic           clr_at_b;
  logic [31:0]    rdat;
  logic [1:0]     resp;
  int             n_checks = 0;
  int             n_fails = 0;

  always #5 clk = ~clk;

  wl_csr_axi_lite_slv dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .axi_lite_req_i (req),
    .axi_lite_rsp_o (rsp),
    .hwpe_busy_i    (busy),
    .hwpe_eoc_i     (eoc),
    .fetch_en_o     (fetch_en),
    .hwpe_clear_o   (clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] bresp);
    logic aw_go, w_go;
    req.aw_addr = addr; req.aw_valid = 1'b1;
    req.w_data = data; req.w_strb = strb; req.w_valid = 1'b1;
    for (int k = 0; k < 20 && (req.aw_valid || req.w_valid); k++) begin
      #1;
      aw_go = rsp.aw_ready;
      w_go  = rsp.w_ready;
      @(negedge clk);
      if (aw_go) req.aw_valid = 1'b0;
      if (w_go) req.w_valid = 1'b0;
    end
    req.aw_valid = 1'b0; req.w_valid = 1'b0;
    for (int k = 0; k < 20 && !rsp.b_valid; k++) @(negedge clk);
    check("b_valid_seen", rsp.b_valid, 1);
    clr_at_b = clr;
    bresp = rsp.b_resp;
    req.b_ready = 1'b1;
    @(negedge clk);
    req.b_ready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] rr);
    logic go;
    req.ar_addr = addr; req.ar_valid = 1'b1;
    for (int k = 0; k < 20 && req.ar_valid; k++) begin
      #1;
      go = rsp.ar_ready;
      @(negedge clk);
      if (go) req.ar_valid = 1'b0;
    end
    req.ar_valid = 1'b0;
    for (int k = 0; k < 20 && !rsp.r_valid; k++) @(negedge clk);
    check("r_valid_seen", rsp.r_valid, 1);
    data = rsp.r_data;
    rr = rsp.r_resp;
    req.r_ready = 1'b1;
    @(negedge clk);
    req.r_ready = 1'b0;
  endtask

  initial begin
    req = '0; busy = 1'b0; eoc = 1'b0; clr_at_b = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_aw_ready", rsp.aw_ready, 0);
    check("rst_w_ready", rsp.w_ready, 0);
    check("rst_ar_ready", rsp.ar_ready, 0);
    check("rst_b_valid", rsp.b_valid, 0);
    check("rst_r_valid", rsp.r_valid, 0);
    check("rst_r_data", rsp.r_data, 0);
    check("rst_resps", {rsp.b_resp, rsp.r_resp}, 0);
    check("rst_fetch_en", fetch_en, 0);
    check("rst_clear", clr, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // AW in cycle 0, W in cycle 3: B and fetch_en in cycle 4.
    req.aw_addr = ACtrl; req.aw_valid = 1'b1;
    #1 check("c0_aw_ready", rsp.aw_ready, 1);
    @(negedge clk);
    req.aw_valid = 1'b0;
    check("c1_aw_ready_held", rsp.aw_ready, 0);
    check("c1_w_ready", rsp.w_ready, 1);
    repeat (2) @(negedge clk);
    req.w_data = 32'h1; req.w_strb = 4'hF; req.w_valid = 1'b1;
    #1 check("c3_b_valid", rsp.b_valid, 0);
    check("c3_fetch_en", fetch_en, 0);
    @(negedge clk);
    req.w_valid = 1'b0;
    check("c4_b_valid", rsp.b_valid, 1);
    check("c4_b_resp", rsp.b_resp, 0);
    check("c4_fetch_en", fetch_en, 1);
    req.b_ready = 1'b1;
    @(negedge clk);
    req.b_ready = 1'b0;
    check("c5_b_valid_low", rsp.b_valid, 0);
    check("c5_aw_ready", rsp.aw_ready, 1);
    axi_read(ACtrl, rdat, resp);
    check("ctrl_rd", rdat, 32'h1);

    // Byte strobes on SCRATCH, and addr[1:0] ignored.
    axi_write(AScr, 32'hAABB_CCDD, 4'hF, resp);
    check("scr_bresp", resp, 0);
    axi_write(AScr, 32'h0000_1100, 4'h2, resp);
    axi_read(AScr, rdat, resp);
    check("scr_strb", rdat, 32'hAABB_11DD);
    check("scr_rresp", resp, 0);
    axi_read(AScr + 32'h3, rdat, resp);
    check("scr_low_bits", rdat, 32'hAABB_11DD);

    // Soft-clear pulse lasts exactly one cycle and reads back as zero.
    axi_write(ACtrl, 32'h2, 4'hF, resp);
    check("clr_pulse_high", clr_at_b, 1);
    check("clr_pulse_low", clr, 0);
    check("clr_fetch_en_off", fetch_en, 0);
    axi_read(ACtrl, rdat, resp);
    check("clr_ctrl_rd", rdat, 0);

    // eoc sticky and live busy.
    eoc = 1'b1;
    @(negedge clk);
    eoc = 1'b0;
    axi_read(AStatus, rdat, resp);
    check("eoc_sticky", rdat, 32'h2);
    busy = 1'b1;
    axi_read(AStatus, rdat, resp);
    check("status_busy", rdat, 32'h3);
    busy = 1'b0;
    req.aw_addr = AStatus; req.aw_valid = 1'b1;
    req.w_data = 32'h2; req.w_strb = 4'hF; req.w_valid = 1'b1;
    eoc = 1'b1;
    @(negedge clk);
    req.aw_valid = 1'b0; req.w_valid = 1'b0; eoc = 1'b0;
    check("eoc_set_wins_bvalid", rsp.b_valid, 1);
    req.b_ready = 1'b1;
    @(negedge clk);
    req.b_ready = 1'b0;
    axi_read(AStatus, rdat, resp);
    check("eoc_set_wins", rdat, 32'h2);
    axi_write(AStatus, 32'h2, 4'hF, resp);
    axi_read(AStatus, rdat, resp);
    check("eoc_cleared", rdat, 0);

    // CYCLES clear on write and wrap.
    axi_write(ACyc, 32'hDEAD_BEEF, 4'hF, resp);
    check("cyc_bresp", resp, 0);
    repeat (9) @(negedge clk);
    axi_read(ACyc, rdat, resp);
    check("cyc_window", {31'b0, (rdat >= 32'd9 && rdat <= 32'd11)}, 1);
    force dut.u_regfile.cycles_q = 32'hFFFF_FFFD;
    @(negedge clk);
    release dut.u_regfile.cycles_q;
    repeat (4) @(negedge clk);
    axi_read(ACyc, rdat, resp);
    check("cyc_wrap", {31'b0, (rdat <= 32'd4)}, 1);

    // Read and write to SCRATCH on the same edge: read sees the old value.
    req.ar_addr = AScr; req.ar_valid = 1'b1;
    req.aw_addr = AScr; req.aw_valid = 1'b1;
    req.w_data = 32'h1234_5678; req.w_strb = 4'hF; req.w_valid = 1'b1;
    @(negedge clk);
    req.ar_valid = 1'b0; req.aw_valid = 1'b0; req.w_valid = 1'b0;
    check("rw_r_valid", rsp.r_valid, 1);
    check("rw_b_valid", rsp.b_valid, 1);
    check("rw_old_data", rsp.r_data, 32'hAABB_11DD);
    req.r_ready = 1'b1; req.b_ready = 1'b1;
    @(negedge clk);
    req.r_ready = 1'b0; req.b_ready = 1'b0;
    axi_read(AScr, rdat, resp);
    check("rw_new_data", rdat, 32'h1234_5678);

    // Out-of-range read of word 7 with r_ready held low for 5 cycles.
    req.ar_addr = CsrBaseAddr + 32'h1C; req.ar_valid = 1'b1;
    @(negedge clk);
    req.ar_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("oor_r_valid_held", rsp.r_valid, 1);
      check("oor_r_data", rsp.r_data, 0);
      check("oor_r_resp", rsp.r_resp, ExpOor);
      @(negedge clk);
    end
    req.r_ready = 1'b1;
    @(negedge clk);
    req.r_ready = 1'b0;
    check("oor_r_done", rsp.r_valid, 0);
    axi_write(CsrBaseAddr + 32'h14, 32'hFFFF_FFFF, 4'hF, resp);
    check("oor_b_resp", resp, ExpOor);
    axi_read(AScr, rdat, resp);
    check("oor_no_change", rdat, 32'h1234_5678);
    axi_read(CsrBaseAddr - 32'h4, rdat, resp);
    check("below_base_data", rdat, 0);
    check("below_base_resp", resp, ExpOor);

    // Reset mid-transaction drops the held AW and clears registers.
    req.aw_addr = ACtrl; req.aw_valid = 1'b1;
    @(negedge clk);
    req.aw_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_aw_ready", rsp.aw_ready, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    axi_read(AScr, rdat, resp);
    check("midrst_scr_zero", rdat, 0);
    req.w_data = 32'h1; req.w_strb = 4'hF; req.w_valid = 1'b1;
    @(negedge clk);
    req.w_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_no_b", rsp.b_valid, 0);
    check("midrst_fetch_en", fetch_en, 0);
    req.aw_addr = AScr; req.aw_valid = 1'b1;
    @(negedge clk);
    req.aw_valid = 1'b0;
    check("midrst_b_after_aw", rsp.b_valid, 1);
    req.b_ready = 1'b1;
    @(negedge clk);
    req.b_ready = 1'b0;
    axi_read(AScr, rdat, resp);
    check("midrst_scr_w", rdat, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
